lpf_decimator: RTL and testbench

LPF_DECIMATOR -- requirements
Module: lpf_decimator

---
 rtl/lpf_pkg.sv | 11 +
 rtl/lpf_decim_fifo.sv | 61 ++++++
 rtl/lpf_decimator.sv | 95 +++++++++
 tb/tb_lpf_decimator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/lpf_pkg.sv
// Shared sample definitions for the LPF chain (FIR stage and decimator).
package lpf_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Log2 of a power-of-two parameter, used for phase and pointer widths.
  function automatic int log2p(input int v);
    return $clog2(v);
  endfunction
endpackage

// File: rtl/lpf_decim_fifo.sv
// Output buffer for the decimator: circular storage with extra-bit pointers
// and a registered head, so the consumer side never sees a combinational path.
module lpf_decim_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] head_q, head_d;
  logic [AW:0]  count;
  logic [AW-1:0] rd_next_idx;

  assign count       = wr_q - rd_q;
  assign empty       = (wr_q == rd_q);
  assign full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd_next_idx = rd_q[AW-1:0] + AW'(1);
  assign head        = head_q;

  // Pointer advance and next head: the entry behind the head is either already
  // stored, or is the one being pushed this cycle when only one remains.
  always_comb begin
    wr_d   = push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d   = pop  ? rd_q + (AW+1)'(1) : rd_q;
    head_d = head_q;
    if (empty && push)
      head_d = wdata;
    else if (pop && count > (AW+1)'(1))
      head_d = mem_q[rd_next_idx];
    else if (pop && push)
      head_d = wdata;
  end

  // Storage is write-only state; not reset so it maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= wdata;
  end

  // Pointers and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end
endmodule

// File: rtl/lpf_decimator.sv
// Decimator after the LPF: keeps every DECIM-th sample (or, with
// LPF_DECIM_AVG_EN defined, the floor average of each DECIM-sample window)
// and buffers results in a small FIFO with a sticky overflow flag.
module lpf_decimator
  import lpf_pkg::*;
#(
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    in_valid,
  input  sample_t in_data,
  output logic    out_valid,
  input  logic    out_ready,
  output sample_t out_data,
  input  logic    ovf_clr,
  output logic    overflow
);
  localparam int PW = log2p(DECIM);

  logic [PW-1:0] phase_q, phase_d;
  logic          overflow_q, overflow_d;
  logic          produce, fifo_full, fifo_empty, fifo_push, fifo_pop, drop;
  sample_t       prod_val;
  logic [SAMPLE_W-1:0] fifo_head;

  assign produce = in_valid && (phase_q == PW'(DECIM - 1));

`ifdef LPF_DECIM_AVG_EN
  localparam int ACC_W = SAMPLE_W + PW;

  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;

  // Window sum including the current sample; restart on the produce edge.
  always_comb begin
    acc_sum  = acc_q + $signed({{PW{in_data[SAMPLE_W-1]}}, in_data});
    prod_val = sample_t'(acc_sum >>> PW);
    acc_d    = acc_q;
    if (produce)       acc_d = '0;
    else if (in_valid) acc_d = acc_sum;
  end

  // Window accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`else
  assign prod_val = in_data;
`endif

  // Accept a produce unless full; a same-cycle transfer frees the slot.
  assign fifo_pop  = ~fifo_empty & out_ready;
  assign fifo_push = produce & (~fifo_full | fifo_pop);
  assign drop      = produce & fifo_full & ~fifo_pop;

  // Phase counter and sticky overflow (a drop beats a clear).
  always_comb begin
    phase_d = phase_q;
    if (in_valid) phase_d = produce ? '0 : phase_q + PW'(1);
    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  // Phase and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  lpf_decim_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .wdata (prod_val),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = sample_t'(fifo_head);
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_lpf_decimator.sv
// Scoreboard bench for lpf_decimator (DECIM=4, FIFO_DEPTH=4). Builds with or
// without LPF_DECIM_AVG_EN; the reference model follows the same macro.
module tb_lpf_decimator;
  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic               ovf_clr = 1'b0;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  lpf_decimator #(.DECIM(DECIM), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          win[$];     // samples of the current window
  logic [15:0] sb[$];      // expected outputs in order
  int          mcnt = 0;   // entries the model believes are buffered
  logic        movf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int window_value();
    int s = 0;
`ifdef LPF_DECIM_AVG_EN
    int r;
    foreach (win[i]) s += win[i];
    r = ((s % DECIM) + DECIM) % DECIM;   // floor division by DECIM
    return (s - r) / DECIM;
`else
    return win[DECIM-1];
`endif
  endfunction

  // One clock: check outputs of the edge just passed, drive inputs, and
  // advance the model for the coming edge.
  task automatic cycle(input bit v, input int d, input bit rdy, input bit clr);
    bit xfer, drop;
    @(posedge clk); #1;
    chk("out_valid", int'(out_valid), int'(mcnt > 0));
    chk("overflow", int'(overflow), int'(movf));
    in_valid  = v;
    in_data   = 16'(d);
    out_ready = rdy;
    ovf_clr   = clr;
    xfer = (mcnt > 0) && rdy;
    drop = 1'b0;
    if (v) begin
      win.push_back(d);
      if (win.size() == DECIM) begin
        if (mcnt < DEPTH || xfer) begin
          sb.push_back(16'(window_value()));
          mcnt++;
        end else drop = 1'b1;
        win.delete();
      end
    end
    if (xfer) mcnt--;
    if (drop)     movf = 1'b1;
    else if (clr) movf = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    win.delete(); sb.delete(); mcnt = 0; movf = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, rdy, 1'b0);
  endtask

  // Monitor: pops expected values on each transfer and checks stability
  // of the head while stalled.
  logic        stall_seen = 1'b0;
  logic [15:0] stall_data;
  always @(negedge clk) begin
    if (reset) stall_seen <= 1'b0;
    else begin
      if (out_valid && stall_seen) begin
        checks++;
        if (out_data !== stall_data) begin
          errors++;
          $display("FAIL stable: got %0d expected %0d", out_data, $signed(stall_data));
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %0d expected none", out_data);
        end else begin
          if (out_data !== sb[0]) begin
            errors++;
            $display("FAIL out_data: got %0d expected %0d", out_data, $signed(sb[0]));
          end
          void'(sb.pop_front());
        end
      end
      stall_seen <= out_valid && !out_ready;
      stall_data <= out_data;
    end
  end

  initial begin
    // reset held from time 0, before any clock edge
    #2;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_out_data", int'(out_data), 0);
    chk("init_overflow", int'(overflow), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // contiguous 1..8, consumer always ready
    for (int i = 1; i <= 8; i++) cycle(1'b1, i, 1'b1, 1'b0);
    idle(4, 1'b1);

    // negative window
    for (int i = 1; i <= 4; i++) cycle(1'b1, -i, 1'b1, 1'b0);
    idle(3, 1'b1);

    // in_valid toggled across 8 samples
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, i, 1'b1, 1'b0);
      cycle(1'b0, 99, 1'b1, 1'b0);
    end
    idle(3, 1'b1);

    // overflow: 20 samples with no consumer, then drain
    for (int i = 1; i <= 20; i++) cycle(1'b1, i, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(8, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b1);   // clear flag
    idle(2, 1'b1);

    // full FIFO with transfer on the produce cycle of sample 20
    for (int i = 1; i <= 19; i++) cycle(1'b1, i, 1'b0, 1'b0);
    cycle(1'b1, 20, 1'b1, 1'b0);
    idle(8, 1'b1);

    // drop and clear in the same cycle: set wins
    for (int i = 1; i <= 19; i++) cycle(1'b1, i, 1'b0, 1'b0);
    cycle(1'b1, 20, 1'b0, 1'b1);
    idle(1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1);
    idle(8, 1'b1);

    // reset mid-window and with buffered data
    cycle(1'b1, 1, 1'b0, 1'b0);
    cycle(1'b1, 2, 1'b0, 1'b0);
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(1'b1, i, 1'b1, 1'b0);
    idle(3, 1'b1);

    for (int i = 1; i <= 6; i++) cycle(1'b1, i, 1'b0, 1'b0);
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(1'b1, i, 1'b1, 1'b0);
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom_range(0, 3) != 0), int'($signed(16'($urandom))),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
    idle(12, 1'b1);

    chk("sb_empty", sb.size(), 0);
    chk("model_empty", mcnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
